// File: rtl/user_module_serial_frame_tx.sv
// rtl/user_module_serial_frame_tx.sv - 5-bit parallel-to-serial frame transmitter (start, data LSB first, even parity, stop)
module user_module_serial_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(CLKS_PER_BIT - 1);

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] data;

    assign clk   = io_in[0];
    assign reset = io_in[1];
    assign start = io_in[2];
    assign data  = io_in[7:3];

    state_t     state;
    logic       txd;
    logic       busy;
    logic       done;
    logic       parity;
    logic       prev_start;
    logic [4:0] shift;
    logic [2:0] bit_idx;
    logic [3:0] div;
    logic       div_last;

    assign div_last = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            txd        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            parity     <= 1'b0;
            prev_start <= 1'b1;
            shift      <= 5'd0;
            bit_idx    <= 3'd0;
            div        <= 4'd0;
        end else begin
            prev_start <= start;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !prev_start) begin
                        shift  <= data;
                        parity <= ^data;
                        state  <= START;
                        busy   <= 1'b1;
                        txd    <= 1'b0;
                        div    <= 4'd0;
                    end
                end
                START: begin
                    if (div_last) begin
                        div     <= 4'd0;
                        state   <= DATA;
                        bit_idx <= 3'd0;
                        txd     <= shift[0];
                    end else begin
                        div <= div + 4'd1;
                    end
                end
                DATA: begin
                    if (div_last) begin
                        div     <= 4'd0;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd4) begin
                            if (PARITY_EN) begin
                                state <= PARITY;
                                txd   <= parity;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            // next bit is already sitting one position up
                            txd <= shift[1];
                        end
                    end else begin
                        div <= div + 4'd1;
                    end
                end
                PARITY: begin
                    if (div_last) begin
                        div   <= 4'd0;
                        state <= STOP;
                        txd   <= 1'b1;
                    end else begin
                        div <= div + 4'd1;
                    end
                end
                STOP: begin
                    if (div_last) begin
                        div   <= 4'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        txd   <= 1'b1;
                    end else begin
                        div <= div + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    div   <= 4'd0;
                end
            endcase
        end
    end

    assign io_out = {1'b0, state, parity, done, busy, txd};

endmodule

// File: tb/tb_user_module_serial_frame_tx.sv
// tb/tb_user_module_serial_frame_tx.sv - frame-level model check of the serial frame transmitter
module tb_user_module_serial_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, rst_b, start_b;
    logic [4:0] data_a, data_b;
    logic [7:0] out_a, out_b;

    user_module_serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (
        .io_in ({data_a, start_a, rst_a, clk}),
        .io_out(out_a)
    );

    user_module_serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut_b (
        .io_in ({data_b, start_b, rst_b, clk}),
        .io_out(out_b)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // frame model: a frame is a list of line bits, each lasting cpb cycles
    int         cpb[2] = '{4, 1};
    int         pe[2]  = '{1, 0};
    bit         m_busy[2], m_done[2], m_par[2], m_prev[2];
    int         m_t[2], m_nb[2];
    logic [7:0] m_bits[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       r, s;
            logic [4:0] d;
            r = (i == 0) ? rst_a : rst_b;
            s = (i == 0) ? start_a : start_b;
            d = (i == 0) ? data_a : data_b;
            if (r) begin
                m_busy[i] = 0; m_done[i] = 0; m_par[i] = 0; m_prev[i] = 1; m_t[i] = 0;
            end else begin
                m_done[i] = 0;
                if (!m_busy[i] && s && !m_prev[i]) begin
                    m_par[i]  = ^d;
                    m_nb[i]   = 7 + pe[i];
                    m_bits[i] = 8'hFF;
                    m_bits[i][0] = 1'b0;
                    for (int k = 0; k < 5; k++) m_bits[i][k+1] = d[k];
                    if (pe[i] != 0) m_bits[i][6] = ^d;
                    m_busy[i] = 1;
                    m_t[i]    = 0;
                end else if (m_busy[i]) begin
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] == m_nb[i] * cpb[i]) begin
                        m_busy[i] = 0;
                        m_done[i] = 1;
                    end
                end
                m_prev[i] = s;
            end
        end
    end

    function automatic logic [7:0] exp_out(int i);
        int         idx;
        logic       t;
        logic [2:0] st;
        if (m_busy[i]) begin
            idx = m_t[i] / cpb[i];
            t   = m_bits[i][idx];
            if (idx == 0)               st = 3'd1;
            else if (idx <= 5)          st = 3'd2;
            else if (idx == m_nb[i]-1)  st = 3'd4;
            else                        st = 3'd3;
        end else begin
            t  = 1'b1;
            st = 3'd0;
        end
        return {1'b0, st, m_par[i], m_done[i], m_busy[i], t};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [7:0] act, want;
                act  = (i == 0) ? out_a : out_b;
                want = exp_out(i);
                checks = checks + 1;
                if (act !== want) begin
                    failures = failures + 1;
                    $display("FAIL model_dut%0d t=%0t got=%b want=%b", i, $time, act, want);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks = checks + 1;
        if (act !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // records dut_a for n cycles after acceptance; optionally pulses start / new data at cycle ev_c
    task automatic capture(input int n, input int ev_c, input logic [4:0] ev_d,
                           output logic [31:0] rec, output int nbusy, output int ndone,
                           output int done_at, output logic [7:0] snap, output logic par33);
        rec = 0; nbusy = 0; ndone = 0; done_at = 0; snap = 0; par33 = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c <= 32) rec = {rec[30:0], out_a[0]};
            nbusy = nbusy + int'(out_a[1]);
            if (out_a[2]) begin ndone = ndone + 1; done_at = c; end
            if (c == 33) par33 = out_a[3];
            if (c == ev_c + 1) snap = out_a;
            if (ev_c != 0 && c == ev_c) begin start_a = 1'b1; data_a = ev_d; end
            if (ev_c != 0 && c == ev_c + 1) start_a = 1'b0;
        end
    endtask

    logic [31:0] rec;
    int          nbusy, ndone, done_at;
    logic [7:0]  snap;
    logic        par33;

    initial begin
        rst_a = 1; rst_b = 1; start_a = 0; start_b = 0; data_a = 0; data_b = 0;
        tick;
        chk_en = 1;
        tick;
        rst_a = 0; rst_b = 0;
        repeat (10) tick;
        chk("idle_a", 32'(out_a), 32'h01);
        chk("idle_b", 32'(out_b), 32'h01);

        // CPB=4 parity frame
        data_a = 5'b10110; start_a = 1; tick; start_a = 0;
        capture(40, 0, 5'd0, rec, nbusy, ndone, done_at, snap, par33);
        chk("a_txd_seq", rec, 32'h00FF0FFF);
        chk("a_busy_len", 32'(nbusy), 32);
        chk("a_done_cnt", 32'(ndone), 1);
        chk("a_done_at", 32'(done_at), 33);
        chk("a_parity", 32'(par33), 1);

        // CPB=1 no-parity frame
        data_b = 5'b00001; start_b = 1; tick; start_b = 0;
        rec = 0; nbusy = 0; ndone = 0; done_at = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 7) rec = {rec[30:0], out_b[0]};
            nbusy = nbusy + int'(out_b[1]);
            if (out_b[2]) begin ndone = ndone + 1; done_at = c; end
        end
        chk("b_txd_seq", rec, 32'b0100001);
        chk("b_busy_len", 32'(nbusy), 7);
        chk("b_done_cnt", 32'(ndone), 1);
        chk("b_done_at", 32'(done_at), 8);
        chk("b_parity", 32'(out_b[3]), 1);

        // mid-frame start and data change are ignored
        tick;
        data_a = 5'b01101; start_a = 1; tick; start_a = 0;
        capture(40, 10, 5'b10010, rec, nbusy, ndone, done_at, snap, par33);
        chk("c_txd_seq", rec, 32'h0F0FF0FF);
        chk("c_busy_len", 32'(nbusy), 32);
        chk("c_done_cnt", 32'(ndone), 1);

        // reset mid-DATA, start held through release
        tick;
        data_a = 5'b10101; start_a = 1; tick; start_a = 0;
        repeat (8) @(negedge clk);
        rst_a = 1; start_a = 1;
        @(negedge clk);
        chk("d_reset_out", 32'(out_a), 32'h01);
        @(negedge clk);
        rst_a = 0;
        nbusy = 0;
        repeat (12) begin @(negedge clk); nbusy = nbusy + int'(out_a[1]); end
        chk("d_held_start", 32'(nbusy), 0);
        start_a = 0;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        chk("d_retrigger", 32'(out_a[1]), 1);
        start_a = 0;
        repeat (40) tick;

        // back-to-back: re-pulse on the done cycle
        data_a = 5'b00000; start_a = 1; tick; start_a = 0;
        capture(34, 33, 5'b11111, rec, nbusy, ndone, done_at, snap, par33);
        chk("e_done_at", 32'(done_at), 33);
        chk("e_next_start", 32'(snap), 32'h1A);
        repeat (40) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
